vram_arbiter: RTL and testbench

- Shares one single-port synchronous pixel RAM (160x120, 8-bit RGB332) between the display scan and a pixel-writer port.
- Sits between VController (hcount, vcount, bright) and ColorSelector, in the clkdiv (pixel clock) domain.
- The display scan has absolute priority on its fetch slots. Writer requests are buffered in a small FIFO and drained into the RAM on every cycle the display does not own.
- Outputs the fetched pixel, upscaled 4x in each axis to 640x480.

---
 rtl/vram_arbiter.sv | 114 +++++++++++
 tb/tb_vram_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// Arbitrates a single-port 160x120 RGB332 pixel RAM between the display scan,
// which owns every fourth active-video cycle, and a FIFO-buffered pixel writer.
module vram_arbiter #(
   parameter int FIFO_DEPTH   = 4,
   parameter int H_SCALE_LOG2 = 2,
   parameter bit BLANK_ONLY   = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [9:0]  hcount,
   input  logic [9:0]  vcount,
   input  logic        bright,
   input  logic        wr_req,
   input  logic [14:0] wr_addr,
   input  logic [7:0]  wr_data,
   output logic        wr_ack,
   output logic        fifo_full,
   output logic        fifo_empty,
   output logic        wr_overflow,
   output logic [14:0] ram_addr,
   output logic        ram_we,
   output logic [7:0]  ram_wdata,
   input  logic [7:0]  ram_rdata,
   output logic [7:0]  pix_rgb
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   // WR is the only state with bit 1 set, so that bit drives ram_we directly from a flop.
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      DISP = 2'b01,
      WR   = 2'b10
   } owner_t;

   typedef struct packed {
      logic [14:0] addr;
      logic [7:0]  data;
   } wr_entry_t;

   owner_t           owner;
   wr_entry_t        fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wptr;
   logic [PTR_W-1:0] rptr;
   logic [CNT_W-1:0] count;
   logic [2:0]       bright_d;
   logic             slot_p2;

   logic        slot;
   logic        drain_ok;
   logic        push;
   logic        pop;
   logic [14:0] row;
   logic [14:0] col;
   logic [14:0] fetch_addr;

   assign row        = 15'(vcount >> H_SCALE_LOG2);
   assign col        = 15'(hcount >> H_SCALE_LOG2);
   assign fetch_addr = (row << 7) + (row << 5) + col;

   assign slot       = bright & (hcount[H_SCALE_LOG2-1:0] == '0);
   assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
   assign fifo_empty = (count == '0);
   assign wr_ack     = wr_req & ~fifo_full & ~rst;
   assign drain_ok   = ~BLANK_ONLY | ~bright_d[2];
   assign push       = wr_ack;
   assign pop        = ~rst & ~slot & ~fifo_empty & drain_ok;
   assign ram_we     = owner[1];

   // NOTE: FIFO storage carries no reset; only count and pointers say which entries are live.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wptr] <= '{addr: wr_addr, data: wr_data};
   end

   // NOTE: all state uses non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         owner       <= IDLE;
         ram_addr    <= '0;
         ram_wdata   <= '0;
         wptr        <= '0;
         rptr        <= '0;
         count       <= '0;
         wr_overflow <= 1'b0;
         bright_d    <= '0;
         slot_p2     <= 1'b0;
         pix_rgb     <= '0;
      end else begin
         if (slot) begin
            owner    <= DISP;
            ram_addr <= fetch_addr;
         end else if (pop) begin
            owner     <= WR;
            ram_addr  <= fifo_mem[rptr].addr;
            ram_wdata <= fifo_mem[rptr].data;
            rptr      <= rptr + 1'b1;
         end else begin
            owner <= IDLE;
         end

         if (push) wptr <= wptr + 1'b1;
         count       <= count + CNT_W'(push) - CNT_W'(pop);
         wr_overflow <= wr_overflow | (wr_req & fifo_full);

         // Fetch data returns one cycle after the DISP cycle; load it on that slot only.
         bright_d <= {bright_d[1:0], bright};
         slot_p2  <= (owner == DISP);
         if (!bright_d[1]) pix_rgb <= '0;
         else if (slot_p2)  pix_rgb <= ram_rdata;
      end
   end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: random scan/writer traffic against a queue-based
// reference model, plus directed blanking, contention, reset and BLANK_ONLY cases.
module tb_vram_arbiter;

   localparam int DEPTH     = 4;
   localparam int RAM_WORDS = 19200;
   localparam int M_NORMAL  = 0;
   localparam int M_CONTEND = 1;
   localparam int M_RSTDRN  = 2;

   typedef struct packed {
      logic [14:0] addr;
      logic [7:0]  data;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  hcount;
   logic [9:0]  vcount;
   logic        bright;
   logic        wr_req;
   logic [14:0] wr_addr;
   logic [7:0]  wr_data;

   logic        wr_ack, fifo_full, fifo_empty, wr_overflow, ram_we;
   logic [14:0] ram_addr;
   logic [7:0]  ram_wdata, ram_rdata, pix_rgb;

   logic        bo_wr_ack, bo_fifo_full, bo_fifo_empty, bo_wr_overflow, bo_ram_we;
   logic [14:0] bo_ram_addr;
   logic [7:0]  bo_ram_wdata, bo_pix_rgb;
   logic [7:0]  bo_ram_rdata;

   always #5 clk = ~clk;
   assign bo_ram_rdata = 8'h00;

   vram_arbiter #(.FIFO_DEPTH(DEPTH), .H_SCALE_LOG2(2), .BLANK_ONLY(1'b0)) u_dut (
      .clk(clk), .rst(rst), .hcount(hcount), .vcount(vcount), .bright(bright),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_ack(wr_ack), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
      .wr_overflow(wr_overflow), .ram_addr(ram_addr), .ram_we(ram_we),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .pix_rgb(pix_rgb)
   );

   vram_arbiter #(.FIFO_DEPTH(DEPTH), .H_SCALE_LOG2(2), .BLANK_ONLY(1'b1)) u_dut_bo (
      .clk(clk), .rst(rst), .hcount(hcount), .vcount(vcount), .bright(bright),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_ack(bo_wr_ack), .fifo_full(bo_fifo_full), .fifo_empty(bo_fifo_empty),
      .wr_overflow(bo_wr_overflow), .ram_addr(bo_ram_addr), .ram_we(bo_ram_we),
      .ram_wdata(bo_ram_wdata), .ram_rdata(bo_ram_rdata), .pix_rgb(bo_pix_rgb)
   );

   // Synchronous single-port pixel RAM, read-first.
   logic [7:0] vram [RAM_WORDS];
   always @(posedge clk) begin
      if (ram_we) vram[ram_addr] <= ram_wdata;
      ram_rdata <= vram[ram_addr];
   end

   // Reference model state.
   wr_t         mq[$];
   logic [7:0]  ref_mem [RAM_WORDS];
   logic [7:0]  pix_pipe[$];
   logic [14:0] m_addr  = '0;
   logic        m_we    = 1'b0;
   logic [7:0]  m_wdata = '0;
   logic        m_ovf   = 1'b0;
   logic [7:0]  m_pix   = '0;
   logic [7:0]  cur_val = '0;
   logic        m_ack;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // One clock: check wr_ack, advance the model at the edge, check registered outputs.
   task automatic step();
      bit  slot;
      wr_t e;
      int  fa;
      #1;
      m_ack = !rst && wr_req && (mq.size() < DEPTH);
      check("wr_ack", wr_ack, m_ack);
      @(posedge clk);
      if (m_we) ref_mem[m_addr] = m_wdata;
      if (rst) begin
         mq.delete();
         pix_pipe.delete();
         m_addr = '0; m_we = 1'b0; m_wdata = '0; m_ovf = 1'b0; m_pix = '0; cur_val = '0;
      end else begin
         slot = bright && (hcount % 4 == 0);
         fa   = (int'(vcount) / 4) * 160 + int'(hcount) / 4;
         if (wr_req && mq.size() == DEPTH) m_ovf = 1'b1;
         if (slot) begin
            m_addr = 15'(fa);
            m_we   = 1'b0;
         end else if (mq.size() > 0) begin
            e       = mq.pop_front();
            m_addr  = e.addr;
            m_wdata = e.data;
            m_we    = 1'b1;
         end else begin
            m_we = 1'b0;
         end
         if (m_ack) mq.push_back('{addr: wr_addr, data: wr_data});
         if (!bright) cur_val = '0;
         else if (slot) cur_val = ref_mem[fa];
         pix_pipe.push_back(cur_val);
         if (pix_pipe.size() == 3) m_pix = pix_pipe.pop_front();
      end
      @(negedge clk);
      cyc++;
      check("ram_we", ram_we, m_we);
      check("ram_addr", ram_addr, m_addr);
      check("ram_wdata", ram_wdata, m_wdata);
      check("pix_rgb", pix_rgb, m_pix);
      check("fifo_empty", fifo_empty, mq.size() == 0);
      check("fifo_full", fifo_full, mq.size() == DEPTH);
      check("wr_overflow", wr_overflow, m_ovf);
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1; wr_req = 1'b0; bright = 1'b0;
      for (int i = 0; i < n; i++) step();
      rst = 1'b0;
   endtask

   task automatic run_line(input int v, input int pct, input int mode);
      int n       = 0;
      int phase   = 0;
      int late_we = 0;
      bit refused = 0;
      bit ref_now;
      for (int h = 0; h < 800; h++) begin
         hcount  = 10'(h);
         vcount  = 10'(v);
         bright  = (h < 640) && (v < 480);
         rst     = 1'b0;
         wr_req  = ($urandom_range(0, 99) < pct);
         wr_addr = 15'($urandom_range(1000, RAM_WORDS - 1));
         wr_data = 8'($urandom);
         if (mode != M_NORMAL && h >= 100 && phase == 0) begin
            wr_req = 1'b1; wr_addr = 15'(2000 + n); wr_data = 8'(n);
         end
         if (mode == M_RSTDRN && phase == 2) begin
            rst = 1'b1; wr_req = 1'b0;
         end
         #1;
         ref_now = (mode == M_CONTEND && phase == 0 && wr_req && !wr_ack);
         if (ref_now) begin refused = 1; phase = 1; end
         if (wr_ack) n++;
         step();
         if (v == 4 && h == 8) begin
            check("scan_addr_162", ram_addr, 162);
            check("scan_read_162", ram_we, 0);
         end
         if (v == 4 && h >= 10 && h <= 13) check("pix_a2_hold", pix_rgb, 8'hA2);
         if (v == 479 && h == 636) check("scan_addr_19199", ram_addr, 19199);
         if (ref_now) check("ovf_on_refusal", wr_overflow, 1);
         if (mode == M_RSTDRN) begin
            case (phase)
               0: if (fifo_full) phase = 1;
               1: begin check("drain_before_rst", ram_we, 1); phase = 2; end
               2: begin
                  check("rst_we_off", ram_we, 0);
                  check("rst_fifo_empty", fifo_empty, 1);
                  phase = 3;
               end
               default: late_we += int'(ram_we);
            endcase
         end
      end
      if (mode == M_CONTEND) begin
         check("contend_refused", refused, 1);
         check("ovf_sticky", wr_overflow, 1);
      end
      if (mode == M_RSTDRN) begin
         check("rstdrain_reached", phase, 3);
         check("rst_no_late_writes", late_we, 0);
      end
   endtask

   task automatic bo_test();
      int early = 0;
      for (int h = 0; h < 800; h++) begin
         hcount = 10'(h); vcount = 10'd8; bright = (h < 640);
         wr_req = (h == 100 || h == 101);
         wr_addr = (h == 100) ? 15'd300 : 15'd301;
         wr_data = (h == 100) ? 8'h11 : 8'h22;
         if (wr_req) begin #1; check("bo_ack", bo_wr_ack, 1); end
         step();
         if (h >= 100 && h <= 642) early += int'(bo_ram_we);
         if (h == 643) begin
            check("bo_we1", bo_ram_we, 1);
            check("bo_addr1", bo_ram_addr, 300);
            check("bo_data1", bo_ram_wdata, 8'h11);
         end
         if (h == 644) begin
            check("bo_we2", bo_ram_we, 1);
            check("bo_addr2", bo_ram_addr, 301);
            check("bo_data2", bo_ram_wdata, 8'h22);
         end
         if (h == 645) begin
            check("bo_we_done", bo_ram_we, 0);
            check("bo_empty", bo_fifo_empty, 1);
            check("bo_not_full", bo_fifo_full, 0);
            check("bo_no_ovf", bo_wr_overflow, 0);
            check("bo_pix_blank", bo_pix_rgb, 0);
         end
      end
      check("bo_hold_in_video", early, 0);
   endtask

   initial begin
      for (int i = 0; i < RAM_WORDS; i++) begin
         vram[i]    = 8'(i);
         ref_mem[i] = 8'(i);
      end
      hcount = '0; vcount = '0; bright = 1'b0;
      wr_addr = 15'd7; wr_data = 8'h55;

      // Reset with a writer request held high.
      rst = 1'b1; wr_req = 1'b1;
      for (int i = 0; i < 3; i++) step();
      #1;
      check("rst_ack", wr_ack, 0);
      check("rst_empty", fifo_empty, 1);
      check("rst_we", ram_we, 0);
      check("rst_pix", pix_rgb, 0);
      check("rst_ovf", wr_overflow, 0);
      rst = 1'b0; wr_req = 1'b0;

      bo_test();

      for (int v = 0; v < 8; v++) run_line(v, 25, M_NORMAL);
      for (int v = 476; v < 480; v++) run_line(v, 25, M_NORMAL);

      // Write during vertical blanking: drain leftovers, then a single push.
      hcount = '0; vcount = 10'd490; bright = 1'b0; wr_req = 1'b0;
      for (int i = 0; i < 16; i++) step();
      check("blank_pre_empty", fifo_empty, 1);
      wr_req = 1'b1; wr_addr = 15'd5; wr_data = 8'h3C;
      #1;
      check("blank_ack", wr_ack, 1);
      step();
      check("blank_lat_we", ram_we, 0);
      check("blank_lat_queued", fifo_empty, 0);
      wr_req = 1'b0;
      step();
      check("blank_we", ram_we, 1);
      check("blank_addr", ram_addr, 5);
      check("blank_data", ram_wdata, 8'h3C);
      check("blank_empty", fifo_empty, 1);
      run_line(491, 40, M_NORMAL);

      do_reset(2);
      check("ovf_clear", wr_overflow, 0);
      run_line(10, 0, M_CONTEND);

      do_reset(2);
      run_line(20, 0, M_RSTDRN);
      run_line(480, 0, M_NORMAL);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
